// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and pixel type for the CNN pooling stage
package cnn_pkg;

  localparam int DATA_W    = 15;
  localparam int NUM_CH    = 9;
  localparam int IMG_W_DEF = 24;
  localparam int IMG_H_DEF = 24;

  typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - half-width line buffer holding the horizontal maxima of an even row
module pool_linebuf #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 135,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // No reset: every entry is written on the even row before the odd row reads it.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/relu_maxpool2.sv
// rtl/relu_maxpool2.sv - 9-channel 2x2 stride-2 signed max-pool over a raster pixel stream
// Define POOL_RELU_EN to clamp negative samples to zero before pooling.
module relu_maxpool2 #(
  parameter int IMG_W  = cnn_pkg::IMG_W_DEF,
  parameter int IMG_H  = cnn_pkg::IMG_H_DEF,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] conv_in_1,
  input  logic signed [DATA_W-1:0] conv_in_2,
  input  logic signed [DATA_W-1:0] conv_in_3,
  input  logic signed [DATA_W-1:0] conv_in_4,
  input  logic signed [DATA_W-1:0] conv_in_5,
  input  logic signed [DATA_W-1:0] conv_in_6,
  input  logic signed [DATA_W-1:0] conv_in_7,
  input  logic signed [DATA_W-1:0] conv_in_8,
  input  logic signed [DATA_W-1:0] conv_in_9,
  input  logic                     valid_in,
  output logic signed [DATA_W-1:0] pool_out_1,
  output logic signed [DATA_W-1:0] pool_out_2,
  output logic signed [DATA_W-1:0] pool_out_3,
  output logic signed [DATA_W-1:0] pool_out_4,
  output logic signed [DATA_W-1:0] pool_out_5,
  output logic signed [DATA_W-1:0] pool_out_6,
  output logic signed [DATA_W-1:0] pool_out_7,
  output logic signed [DATA_W-1:0] pool_out_8,
  output logic signed [DATA_W-1:0] pool_out_9,
  output logic                     valid_out,
  output logic                     frame_done
);

  import cnn_pkg::*;

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LB_W     = NUM_CH * DATA_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic signed [DATA_W-1:0] x      [NUM_CH];
  logic signed [DATA_W-1:0] r      [NUM_CH];
  logic signed [DATA_W-1:0] h      [NUM_CH];
  logic signed [DATA_W-1:0] lb_rd  [NUM_CH];
  logic signed [DATA_W-1:0] hreg_q [NUM_CH];
  logic signed [DATA_W-1:0] hreg_d [NUM_CH];
  logic signed [DATA_W-1:0] pool_q [NUM_CH];
  logic signed [DATA_W-1:0] pool_d [NUM_CH];

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            lb_we;
  logic [AW-1:0]   lb_addr;
  logic [LB_W-1:0] lb_wdata;
  logic [LB_W-1:0] lb_rdata;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign x[0] = conv_in_1;
  assign x[1] = conv_in_2;
  assign x[2] = conv_in_3;
  assign x[3] = conv_in_4;
  assign x[4] = conv_in_5;
  assign x[5] = conv_in_6;
  assign x[6] = conv_in_7;
  assign x[7] = conv_in_8;
  assign x[8] = conv_in_9;

  // Each pooling window's column pair shares one line-buffer slot.
  assign lb_addr = AW'(col_q >> 1);

  pool_linebuf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (LB_W)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (lb_wdata),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    hreg_d   = hreg_q;
    pool_d   = pool_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    lb_we    = 1'b0;
    lb_wdata = '0;

    for (int k = 0; k < NUM_CH; k++) begin
`ifdef POOL_RELU_EN
      r[k] = x[k][DATA_W-1] ? '0 : x[k];
`else
      r[k] = x[k];
`endif
      h[k]     = smax(hreg_q[k], r[k]);
      lb_rd[k] = lb_rdata[k*DATA_W +: DATA_W];
      lb_wdata[k*DATA_W +: DATA_W] = h[k];
    end

    if (valid_in) begin
      if (!col_q[0]) begin
        hreg_d = r;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          pool_d[k] = smax(lb_rd[k], h[k]);
        end
        valid_d = 1'b1;
        done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        hreg_q[k] <= '0;
        pool_q[k] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      hreg_q  <= hreg_d;
      pool_q  <= pool_d;
    end
  end

  assign pool_out_1 = pool_q[0];
  assign pool_out_2 = pool_q[1];
  assign pool_out_3 = pool_q[2];
  assign pool_out_4 = pool_q[3];
  assign pool_out_5 = pool_q[4];
  assign pool_out_6 = pool_q[5];
  assign pool_out_7 = pool_q[6];
  assign pool_out_8 = pool_q[7];
  assign pool_out_9 = pool_q[8];
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_relu_maxpool2.sv
// tb/tb_relu_maxpool2.sv - directed checks of relu_maxpool2 on a 4x2 and a default 24x24 instance
module tb_relu_maxpool2;

  localparam int DW = 15;
  localparam int W  = 24;
  localparam int H  = 24;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] cin [9];
  logic signed [DW-1:0] pb  [9];
  logic signed [DW-1:0] ps  [9];
  logic                 vb, fb, vs, fs;

  int n_chk  = 0;
  int n_fail = 0;
  int small_px [8] = '{1, 5, 2, 3, 4, 0, 7, 6};

  always #5 clk = ~clk;

  relu_maxpool2 u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_in_1  (cin[0]),
    .conv_in_2  (cin[1]),
    .conv_in_3  (cin[2]),
    .conv_in_4  (cin[3]),
    .conv_in_5  (cin[4]),
    .conv_in_6  (cin[5]),
    .conv_in_7  (cin[6]),
    .conv_in_8  (cin[7]),
    .conv_in_9  (cin[8]),
    .valid_in   (valid_in),
    .pool_out_1 (pb[0]),
    .pool_out_2 (pb[1]),
    .pool_out_3 (pb[2]),
    .pool_out_4 (pb[3]),
    .pool_out_5 (pb[4]),
    .pool_out_6 (pb[5]),
    .pool_out_7 (pb[6]),
    .pool_out_8 (pb[7]),
    .pool_out_9 (pb[8]),
    .valid_out  (vb),
    .frame_done (fb)
  );

  relu_maxpool2 #(
    .IMG_W  (4),
    .IMG_H  (2),
    .DATA_W (DW)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_in_1  (cin[0]),
    .conv_in_2  (cin[1]),
    .conv_in_3  (cin[2]),
    .conv_in_4  (cin[3]),
    .conv_in_5  (cin[4]),
    .conv_in_6  (cin[5]),
    .conv_in_7  (cin[6]),
    .conv_in_8  (cin[7]),
    .conv_in_9  (cin[8]),
    .valid_in   (valid_in),
    .pool_out_1 (ps[0]),
    .pool_out_2 (ps[1]),
    .pool_out_3 (ps[2]),
    .pool_out_4 (ps[3]),
    .pool_out_5 (ps[4]),
    .pool_out_6 (ps[5]),
    .pool_out_7 (ps[6]),
    .pool_out_8 (ps[7]),
    .pool_out_9 (ps[8]),
    .valid_out  (vs),
    .frame_done (fs)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pixval(int mode, int r, int c, int k);
    case (mode)
      0:       return -100;
      1:       return ((r * 37 + c * 11 + k * 53) % 301) - 150;
      2:       return k * 10;
      3:       return (k == 9) ? 16383 : k * 10;
      default: return (k == 9) ? -16384 : k * 10;
    endcase
  endfunction

  function automatic int act(int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int exp_pool(int mode, int r, int c, int k);
    int m;
    int v;
    m = act(pixval(mode, r - 1, c - 1, k));
    v = act(pixval(mode, r - 1, c, k));
    if (v > m) m = v;
    v = act(pixval(mode, r, c - 1, k));
    if (v > m) m = v;
    v = act(pixval(mode, r, c, k));
    if (v > m) m = v;
    return m;
  endfunction

  task automatic run_frame(input int mode, input bit toggle, input int npix, input string tag);
    int nv;
    int nf;
    int idx;
    bit out;
    bit last;
    nv  = 0;
    nf  = 0;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (idx < npix) begin
          for (int k = 0; k < 9; k++) cin[k] = DW'(pixval(mode, r, c, k + 1));
          valid_in = 1'b1;
          clk_step();
          valid_in = 1'b0;
          out  = (r % 2 == 1) && (c % 2 == 1);
          last = (r == H - 1) && (c == W - 1);
          if (vb === 1'b1) nv++;
          if (fb === 1'b1) nf++;
          chk({tag, " valid_out"}, vb, out);
          chk({tag, " frame_done"}, fb, last);
          if (out) begin
            for (int k = 0; k < 9; k++)
              chk($sformatf("%s pool_out_%0d r%0d c%0d", tag, k + 1, r, c), pb[k], exp_pool(mode, r, c, k + 1));
          end
          if (toggle) begin
            clk_step();
            if (vb === 1'b1) nv++;
            if (fb === 1'b1) nf++;
            chk({tag, " idle valid_out"}, vb, 0);
            if (out) chk($sformatf("%s hold pool_out_1 r%0d c%0d", tag, r, c), pb[0], exp_pool(mode, r, c, 1));
          end
          idx++;
        end
      end
    end
    if (npix == W * H) begin
      chk({tag, " valid_out count"}, nv, (W / 2) * (H / 2));
      chk({tag, " frame_done count"}, nf, 1);
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) cin[k] = '0;
    repeat (3) clk_step();
    chk("reset valid_out", vb, 0);
    chk("reset frame_done", fb, 0);
    chk("reset pool_out_1", pb[0], 0);
    chk("reset pool_out_9", pb[8], 0);
    chk("reset small valid_out", vs, 0);
    rst_n = 1'b1;
    clk_step();

    // 4x2 frame: channel 1 rows [1,5,2,3] / [4,0,7,6]
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 9; k++) cin[k] = '0;
      cin[0]   = DW'(small_px[i]);
      valid_in = 1'b1;
      clk_step();
      valid_in = 1'b0;
      chk($sformatf("small valid_out px%0d", i), vs, (i == 5 || i == 7));
      chk($sformatf("small frame_done px%0d", i), fs, (i == 7));
      if (i == 5) chk("small pool_out_1 first", ps[0], 5);
      if (i == 7) begin
        chk("small pool_out_1 second", ps[0], 7);
        chk("small pool_out_2", ps[1], 0);
      end
    end
    clk_step();
    chk("small idle valid_out", vs, 0);
    chk("small hold pool_out_1", ps[0], 7);

    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;

    run_frame(0, 1'b0, W * H, "neg100");
    run_frame(1, 1'b1, W * H, "toggle");

    // Partial frame, then an asynchronous reset between clock edges
    run_frame(1, 1'b0, 30, "partial");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid_out", vb, 0);
    chk("async reset frame_done", fb, 0);
    for (int k = 0; k < 9; k++) chk($sformatf("async reset pool_out_%0d", k + 1), pb[k], 0);
    clk_step();
    rst_n = 1'b1;

    run_frame(2, 1'b0, W * H, "k10");
    run_frame(3, 1'b0, W * H, "frame1");
    run_frame(4, 1'b0, W * H, "frame2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2.md
RELU_MAXPOOL2 -- requirements
Module: relu_maxpool2

Interface
REQ-001 SHALL provide parameter IMG_W, default 24, input feature-map width in pixels (even, >=2).
REQ-002 SHALL provide parameter IMG_H, default 24, input feature-map height in rows (even, >=2).
REQ-003 SHALL provide parameter DATA_W, default 15, signed sample width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset. Ports: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-005 SHALL provide conv_in_1..conv_in_9, input, DATA_W signed each: one pixel of 9 channels from the pointwise stage.
REQ-006 SHALL provide valid_in, input, 1: conv_in_* valid this cycle; sampled every cycle, no backpressure.
REQ-007 SHALL provide pool_out_1..pool_out_9, output, DATA_W signed each: pooled pixel per channel.
REQ-008 SHALL provide valid_out, output, 1: single-cycle pulse per pooled pixel.
REQ-009 SHALL provide frame_done, output, 1: single-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-010 SHALL accept pixels in raster order, one per valid_in cycle, IMG_W*IMG_H pixels per frame; cycles with valid_in=0 SHALL leave all state unchanged.
REQ-011 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) counters; col wraps to 0 and row increments after col=IMG_W-1; row wraps to 0 after the last pixel of a frame.
REQ-012 SHALL apply ReLU per channel: r = (x<0) ? 0 : x (see REQ-021).
REQ-013 On even col, SHALL store r in a per-channel horizontal register.
REQ-014 On odd col, SHALL form h = max(horizontal register, r) per channel.
REQ-015 On odd col of an even row, SHALL write h into line-buffer entry col>>1 (IMG_W/2 entries x 9 channels x DATA_W); no output.
REQ-016 On odd col of an odd row, SHALL register pool_out_k = max(linebuf[col>>1], h) and assert valid_out on the next clock edge; latency is exactly 1 cycle from the accepting edge.
REQ-017 pool_out_* SHALL hold their last value while valid_out=0.
REQ-018 SHALL assert frame_done together with valid_out for the pixel at row=IMG_H-1, col=IMG_W-1; a new frame SHALL be accepted on the next valid_in cycle with no gap.
REQ-019 Comparisons SHALL be signed, DATA_W wide, with no truncation or saturation; ties select either operand (equal values).

Reset
REQ-020 On rst_n low: col, row, horizontal registers, pool_out_* = 0, valid_out = 0, frame_done = 0, immediately and asynchronously; line-buffer contents need not be cleared; a partial frame in flight SHALL be discarded and the next accepted pixel treated as row 0, col 0.

Configuration
REQ-021 Macro POOL_RELU_EN: when defined, REQ-012 ReLU is applied; when undefined, r = x (pure signed 2x2 max-pool, negative outputs possible).

Structure
REQ-022 Package cnn_pkg SHALL hold DATA_W, NUM_CH=9, default IMG_W/IMG_H, and the pixel typedef (signed DATA_W); relu_maxpool2 SHALL import it.
REQ-023 Line buffer SHALL be a sub-module pool_linebuf (one write port, one read port, combinational read by address, IMG_W/2 deep, NUM_CH*DATA_W wide).

Verification
REQ-024 IMG_W=4, IMG_H=2, channel 1 rows [1,5,2,3] / [4,0,7,6], valid_in continuous -> two valid_out pulses with pool_out_1 = 5 then 7; frame_done with the second.
REQ-025 POOL_RELU_EN defined, all channels = -100 for a full frame -> every pool_out_k = 0; undefined -> every pool_out_k = -100.
REQ-026 Default 24x24 frame with valid_in toggling 1/0 -> exactly 144 valid_out pulses, one frame_done, values match the reference model.
REQ-027 rst_n pulsed low after 30 pixels, then full frame of channel k = k*10 -> 144 outputs all equal k*10; no output from the partial frame.
REQ-028 Two back-to-back frames, channel 9 = +16383 in frame 1 and -16384 in frame 2 (relu off) -> outputs 16383 then -16384, no overflow, frame_done twice.
